// File: rtl/button_pulse_gen.sv
// button_pulse_gen: turns raw push-button levels into clean single-cycle strobes.
// Each button passes through a 2-FF synchronizer, a debounce FSM and a press/long-press
// strobe stage. Buttons are fully independent.
//
// Ports:
//   Clk       - system clock, rising edge
//   Rst       - asynchronous, active-high reset
//   btn_n     - raw button levels, active-low, asynchronous to Clk
//   fPress_n  - one-cycle active-low strobe per accepted press
//   fHold_n   - one-cycle active-low strobe after HOLD_CYCLES of continuous press
//   btn_level - debounced level, 1 while the button is considered held
module button_pulse_gen #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] fPress_n,
  output logic [NUM_BTN-1:0] fHold_n,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HcntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcntW-1:0] HcntLast = HcntW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  // Synchronizer resets to the released level so no phantom press follows reset.
  logic [NUM_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [HcntW-1:0] hcnt_q, hcnt_d;
    logic             hold_done_q, hold_done_d;
    logic             press_n_q, press_n_d;
    logic             hold_n_q, hold_n_d;
    logic             level_q, level_d;
    logic             p;

    assign p = ~sync2_q[i];

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        hcnt_q      <= '0;
        hold_done_q <= 1'b0;
        press_n_q   <= 1'b1;
        hold_n_q    <= 1'b1;
        level_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        hcnt_q      <= hcnt_d;
        hold_done_q <= hold_done_d;
        press_n_q   <= press_n_d;
        hold_n_q    <= hold_n_d;
        level_q     <= level_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hcnt_d      = hcnt_q;
      hold_done_d = hold_done_q;
      unique case (state_q)
        StIdle: begin
          if (p) begin
            state_d = StPressWait;
            cnt_d   = '0;
          end
        end
        StPressWait: begin
          if (!p) begin
            state_d = StIdle;
          end else if (cnt_q == CntLast) begin
            state_d     = StPressed;
            hcnt_d      = '0;
            hold_done_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!p) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end else if (hcnt_q == HcntLast && !hold_done_q) begin
            hold_done_d = 1'b1;
          end else if (hcnt_q != HcntLast) begin
            hcnt_d = hcnt_q + HcntW'(1);
          end
        end
        StReleaseWait: begin
          // A bounce back to pressed keeps the hold progress.
          if (p) begin
            state_d = StPressed;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
      press_n_d = !(state_q == StPressWait && p && cnt_q == CntLast);
      hold_n_d  = !(state_q == StPressed && p && hcnt_q == HcntLast && !hold_done_q);
      level_d   = (state_d == StPressed) || (state_d == StReleaseWait);
    end

    assign fPress_n[i]  = press_n_q;
    assign fHold_n[i]   = hold_n_q;
    assign btn_level[i] = level_q;
  end

endmodule
